// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, LSB-first data, optional parity, stop bit.
// Every output is a flop, so Tx never glitches.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       Tx,
  output logic       busy,
  output logic       finish
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic          par_q;
  logic          tx_q;
  logic          busy_q;
  logic          fin_q;
  logic          bit_end;
  logic          fin_next;

  assign bit_end  = (cnt_q == LAST);
  // finish is registered, so it is raised on the edge entering the last STOP cycle
  assign fin_next = ((cnt_q + CW'(1)) == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          idx_q  <= '0;
          if (start) begin
            sh_q    <= data;
            par_q   <= (^data) ^ PARITY_ODD;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= sh_q[0];
            sh_q    <= {1'b0, sh_q[7:1]};
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              idx_q <= '0;
              if (PARITY_EN) begin
                tx_q    <= par_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                fin_q   <= (CLKS_PER_BIT == 1);
                state_q <= STOP;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= sh_q[0];
              sh_q  <= {1'b0, sh_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            fin_q   <= (CLKS_PER_BIT == 1);
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            fin_q <= fin_next;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign Tx     = tx_q;
  assign busy   = busy_q;
  assign finish = fin_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no parity, even, odd
// parity and one clock per bit.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [3:0] st;
  logic [7:0] data;
  logic [3:0] tx;
  logic [3:0] bz;
  logic [3:0] fn;
  int         tests;
  int         fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .data(data),
    .Tx(tx[0]), .busy(bz[0]), .finish(fn[0]));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .data(data),
    .Tx(tx[1]), .busy(bz[1]), .finish(fn[1]));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .data(data),
    .Tx(tx[2]), .busy(bz[2]), .finish(fn[2]));
  uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .data(data),
    .Tx(tx[3]), .busy(bz[3]), .finish(fn[3]));

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int k, input logic [7:0] d);
    @(negedge clk);
    st[k] = 1'b1;
    data  = d;
  endtask

  // Called after the accepting edge is queued; walks the frame one cycle
  // at a time from the first START cycle, acting as line monitor and RX.
  task automatic frame(input int k, input logic [7:0] d, input int pbit,
                       input int extra, input bit disturb);
    int n, nb, errs, bc, fc, fp, pb;
    logic [10:0] bits;
    logic [7:0]  rx;
    logic        e;
    n    = (k == 3) ? 1 : 16;
    nb   = (k == 1 || k == 2) ? 11 : 10;
    errs = 0; bc = 0; fc = 0; fp = -1; pb = -1;
    rx   = 8'h00;
    bits = 11'h7ff;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (nb == 11) bits[9] = pbit[0];
    for (int c = 0; c < nb * n + extra; c++) begin
      @(negedge clk);
      if (c == 0) st = 4'b0;
      if (disturb && c == 40) begin st[k] = 1'b1; data = 8'hFF; end
      if (disturb && c == 41) st[k] = 1'b0;
      e = (c < nb * n) ? bits[c / n] : 1'b1;
      if (tx[k] !== e) errs++;
      if (bz[k]) bc++;
      if (fn[k]) begin fc++; fp = c; end
      if (c < nb * n && (c % n) == n / 2) begin
        if (c / n >= 1 && c / n <= 8) rx[c / n - 1] = tx[k];
        if (c / n == 9 && nb == 11) pb = int'(tx[k]);
      end
    end
    chk($sformatf("u%0d txseq errs", k), errs, 0);
    chk($sformatf("u%0d rx byte", k), int'(rx), int'(d));
    chk($sformatf("u%0d busy cycles", k), bc, nb * n);
    chk($sformatf("u%0d finish count", k), fc, 1);
    chk($sformatf("u%0d finish pos", k), fp, nb * n - 1);
    if (nb == 11) chk($sformatf("u%0d parity", k), pb, pbit);
  endtask

  initial begin
    int fc;
    tests = 0;
    fails = 0;
    st    = 4'b0;
    data  = 8'h00;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", int'(tx), 4'hf);
    chk("reset busy", int'(bz), 0);
    chk("reset finish", int'(fn), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle tx", int'(tx), 4'hf);

    pulse(0, 8'h35);
    frame(0, 8'h35, 0, 0, 1'b0);
    // start during the finish cycle must be ignored; kept high into IDLE
    st[0] = 1'b1;
    data  = 8'h02;
    @(negedge clk);
    chk("u0 idle gap busy", int'(bz[0]), 0);
    chk("u0 idle gap tx", int'(tx[0]), 1);
    frame(0, 8'h02, 0, 20, 1'b0);

    pulse(1, 8'h35);
    frame(1, 8'h35, 0, 4, 1'b0);
    pulse(2, 8'h35);
    frame(2, 8'h35, 1, 4, 1'b0);

    pulse(0, 8'h5A);
    frame(0, 8'h5A, 0, 30, 1'b1);

    pulse(0, 8'h3C);
    fc = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c == 0) st = 4'b0;
      if (fn[0]) fc++;
    end
    rst = 1'b1;
    #1;
    chk("abort tx", int'(tx[0]), 1);
    chk("abort busy", int'(bz[0]), 0);
    chk("abort finish", int'(fn[0]), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (fn[0]) fc++;
    end
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (fn[0]) fc++;
    end
    chk("abort no finish", fc, 0);
    pulse(0, 8'hA5);
    frame(0, 8'hA5, 0, 4, 1'b0);

    pulse(3, 8'h80);
    frame(3, 8'h80, 0, 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
